fwrisc_dbus_target: RTL and testbench

Responder (slave) end of the fwrisc external data bus (dvalid/daddr/dwdata/dwstb/dwrite/drdata/dready). It provides a single-port, byte-strobed, word-organised local data RAM with a programmable number of wait states and a base-address decode. Every access returns the prior word contents, so atomic swap-style writes get their old value back. It is used as the data memory in the core testbench and in small SoC builds.

---
 rtl/fwrisc_dbus_target_pkg.sv | 20 ++
 rtl/fwrisc_dbus_ram.sv | 30 +++
 rtl/fwrisc_dbus_target.sv | 112 +++++++++++
 tb/tb_fwrisc_dbus_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_dbus_target_pkg.sv
// Shared definitions for the fwrisc data-bus target: FSM state encodings,
// the default out-of-range read value and the base-region decode helper.
package fwrisc_dbus_target_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_RESP = 2'd2
    } state_e;

    localparam logic [31:0] OOR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // True when addr falls in the aligned region of 2**lsb bytes that starts at base
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          lsb);
        return (addr >> lsb) == (base >> lsb);
    endfunction

endpackage

// File: rtl/fwrisc_dbus_ram.sv
// Word-organised single-port RAM with per-byte write strobes.
// Registered read returns the word as it was before a same-cycle write.
module fwrisc_dbus_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstb,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= r_mem[addr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstb[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/fwrisc_dbus_target.sv
// Responder end of the fwrisc data bus: local byte-strobed RAM behind a
// base-address decode, with programmable wait states and a sticky error flag.
module fwrisc_dbus_target
    import fwrisc_dbus_target_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] OOR_RDATA   = OOR_RDATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        err,
    output logic        busy
);

    localparam int REGION_LSB = ADDR_BITS + 2;

    state_e                r_state;
    logic [3:0]            r_count;
    logic [ADDR_BITS-1:0]  r_word;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstb;
    logic                  r_write;
    logic                  r_in_range;
    logic                  r_dready;
    logic                  r_err;
    logic                  r_busy;

    logic                  w_access;
    logic [31:0]           w_ram_rdata;

    // Gated by reset so an access caught by reset never commits its write
    assign w_access = (r_state == STATE_WAIT) && dvalid && (r_count == 4'd0) && !reset;

    fwrisc_dbus_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .addr  (r_word),
        .wdata (r_wdata),
        .wstb  (r_wstb),
        .we    (w_access && r_write && r_in_range),
        .re    (w_access && r_in_range),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= STATE_IDLE;
            r_count  <= 4'd0;
            r_dready <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    r_dready <= 1'b0;
                    if (dvalid) begin
                        r_word     <= daddr[ADDR_BITS+1:2];
                        r_wdata    <= dwdata;
                        r_wstb     <= dwstb;
                        r_write    <= dwrite;
                        r_in_range <= in_region(daddr, BASE_ADDR, REGION_LSB);
                        r_count    <= 4'(WAIT_STATES);
                        r_busy     <= 1'b1;
                        r_state    <= STATE_WAIT;
                    end
                end
                STATE_WAIT: begin
                    if (!dvalid) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= STATE_IDLE;
                    end else if (r_count == 4'd0) begin
                        r_dready <= 1'b1;
                        if (!r_in_range) begin
                            r_err <= 1'b1;
                        end
                        r_state <= STATE_RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                STATE_RESP: begin
                    r_dready <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= STATE_IDLE;
                end
                default: begin
                    r_dready <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= STATE_IDLE;
                end
            endcase
        end
    end

    // RAM read data is registered on the access edge, so it lines up with dready
    assign drdata = r_dready ? (r_in_range ? w_ram_rdata : OOR_RDATA) : 32'h0;
    assign dready = r_dready;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule

// File: tb/tb_fwrisc_dbus_target.sv
// Scoreboard bench for fwrisc_dbus_target: one instance with no wait states
// and one with three, sharing clock, reset and the request fields.
module tb_fwrisc_dbus_target;

    logic        clock = 1'b0;
    logic        reset;
    logic        dvalid0, dvalid1;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic [31:0] drdata0, drdata1;
    logic        dready0, dready1, err0, err1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clock = ~clock;

    fwrisc_dbus_target #(.WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset), .dvalid(dvalid0), .daddr(daddr),
        .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite), .drdata(drdata0),
        .dready(dready0), .err(err0), .busy(busy0)
    );

    fwrisc_dbus_target #(.WAIT_STATES(3)) u_dut1 (
        .clock(clock), .reset(reset), .dvalid(dvalid1), .daddr(daddr),
        .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite), .drdata(drdata1),
        .dready(dready1), .err(err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic access(input int which, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] stb, input logic wr, input logic do_chk,
                          input logic [31:0] exp, input logic toggle);
        int  n;
        logic seen;
        if (which == 0) q0.push_back({do_chk, exp});
        else            q1.push_back({do_chk, exp});
        daddr  = a;
        dwdata = wd;
        dwstb  = stb;
        dwrite = wr;
        if (which == 0) dvalid0 = 1'b1;
        else            dvalid1 = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (toggle && n == 1) daddr = a ^ 32'h4;
            seen = (which == 0) ? dready0 : dready1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no dready on dut%0d for addr %08h", which, a);
            dvalid0 = 1'b0;
            dvalid1 = 1'b0;
        end else begin
            chk("latency", 32'(n), (which == 0) ? 32'd2 : 32'd5);
            @(posedge clock); #1;
            dvalid0 = 1'b0;
            dvalid1 = 1'b0;
            chk("dready_width", {31'd0, (which == 0) ? dready0 : dready1}, 32'd0);
        end
    endtask

    initial begin
        logic [32:0] e;
        reset   = 1'b1;
        dvalid0 = 1'b0;
        dvalid1 = 1'b0;
        daddr   = 32'h0;
        dwdata  = 32'h0;
        dwstb   = 4'h0;
        dwrite  = 1'b0;

        // Response monitor: pops the scoreboard whenever either target responds
        fork
            forever begin
                @(negedge clock);
                if (!reset) begin
                    if (dready0) begin
                        if (q0.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_dready0: drdata %08h with nothing expected", drdata0);
                        end else begin
                            e = q0.pop_front();
                            if (e[32]) chk("rdata0", drdata0, e[31:0]);
                        end
                    end
                    if (dready1) begin
                        if (q1.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_dready1: drdata %08h with nothing expected", drdata1);
                        end else begin
                            e = q1.pop_front();
                            if (e[32]) chk("rdata1", drdata1, e[31:0]);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clock);
        #1;
        chk("rst_dready0", {31'd0, dready0}, 32'd0);
        chk("rst_drdata0", drdata0, 32'd0);
        chk("rst_err0",    {31'd0, err0}, 32'd0);
        chk("rst_busy0",   {31'd0, busy0}, 32'd0);
        chk("rst_dready1", {31'd0, dready1}, 32'd0);
        chk("rst_err1",    {31'd0, err1}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Word write / read-before-write / read back
        access(0, 32'h8000_0010, 32'h1111_1111, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h8000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        access(0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        chk("busy_idle0", {31'd0, busy0}, 32'd0);

        // Byte and halfword strobes
        access(0, 32'h8000_0013, 32'hAAAA_AAAA, 4'b1000, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        access(0, 32'h8000_0010, 32'hBBBB_BBBB, 4'b0011, 1'b1, 1'b1, 32'hAA34_5678, 1'b0);
        access(0, 32'h8000_0010, 32'h0,         4'h0,    1'b0, 1'b1, 32'hAA34_BBBB, 1'b0);

        // Write with no strobes changes nothing
        access(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b1, 32'hAA34_BBBB, 1'b0);
        access(0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA34_BBBB, 1'b0);

        // Atomic swap
        access(0, 32'h8000_0020, 32'h0000_0005, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h8000_0020, 32'h0000_0009, 4'hF, 1'b1, 1'b1, 32'h0000_0005, 1'b0);
        access(0, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_0009, 1'b0);
        chk("err0_clean", {31'd0, err0}, 32'd0);

        // Out of range: read, then a write aliasing word 8 must be dropped
        access(0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("err0_oor", {31'd0, err0}, 32'd1);
        access(0, 32'h0000_1020, 32'h7777_7777, 4'hF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        access(0, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_0009, 1'b0);
        chk("err0_sticky", {31'd0, err0}, 32'd1);

        // Three wait states; address wiggled during WAIT is ignored
        access(1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(1, 32'h8000_0044, 32'h0BAD_C0DE, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(1, 32'h8000_0040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        chk("err1_clean", {31'd0, err1}, 32'd0);

        // Abort: dvalid dropped in WAIT
        daddr = 32'h8000_0040; dwdata = 32'h5555_5555; dwstb = 4'hF; dwrite = 1'b1;
        dvalid1 = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        dvalid1 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("abort_err1",  {31'd0, err1}, 32'd1);
        chk("abort_busy1", {31'd0, busy1}, 32'd0);
        access(1, 32'h8000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        chk("err0_still", {31'd0, err0}, 32'd1);

        // Reset in the middle of a write
        daddr = 32'h8000_0040; dwdata = 32'h6666_6666; dwstb = 4'hF; dwrite = 1'b1;
        dvalid1 = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("busy1_wait", {31'd0, busy1}, 32'd1);
        reset   = 1'b1;
        dvalid1 = 1'b0;
        @(posedge clock); #1;
        chk("midrst_dready1", {31'd0, dready1}, 32'd0);
        chk("midrst_drdata1", drdata1, 32'd0);
        chk("midrst_err1",    {31'd0, err1}, 32'd0);
        chk("midrst_busy1",   {31'd0, busy1}, 32'd0);
        chk("midrst_err0",    {31'd0, err0}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        access(1, 32'h8000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        chk("post_rst_err1", {31'd0, err1}, 32'd0);

        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
